// File: rtl/bram_arb_pkg.sv
// Shared types and the round-robin pick helper for the block-RAM arbiter.
package bram_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PTR_W   = 4;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

    // One-hot grant of the first set bit of valid at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input logic [PTR_W:0]     n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [PTR_W:0]     idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= n) idx = idx - n;
            if (!found && ((PTR_W+1)'(k) < n) && valid[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/arb_rr_core.sv
// Masked round-robin picker: one-hot grant plus its binary index.
module arb_rr_core
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         mask_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req_i & mask_i), PTR_W'(ptr_i), (PTR_W+1)'(NUM_REQ));
        gnt_o = pick[NUM_REQ-1:0];
        idx_o = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM, with optional grant lock.
// Define BRAM_ARB_CNT_EN to build saturating per-requester grant counters.
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 13,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0]                req_write_i,
    input  logic [NUM_REQ-1:0]                req_lock_i,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0]  req_addr_i,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    output logic [RAM_WIDTH-1:0]              rsp_data_o,
    output logic                              ram_we_o,
    output logic                              ram_re_o,
    output logic [RAM_ADDR_BITS-1:0]          ram_addr_o,
    output logic [RAM_WIDTH-1:0]              ram_wdata_o,
    input  logic [RAM_WIDTH-1:0]              ram_rdata_i,
    output logic [NUM_REQ*CNT_WIDTH-1:0]      grant_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t           state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [RAM_WIDTH-1:0] rsp_hold_q;

    logic [NUM_REQ-1:0]   mask;
    logic [NUM_REQ-1:0]   core_gnt;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gidx;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic                 accept;

    // While locked only the owner is eligible.
    always_comb begin
        mask = '1;
        if (state_q == LOCKED) begin
            mask          = '0;
            mask[owner_q] = 1'b1;
        end
    end

    arb_rr_core #(.NUM_REQ(NUM_REQ)) u_core (
        .req_i  (req_valid_i),
        .mask_i (mask),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (core_gnt),
        .idx_o  (gidx)
    );

    always_comb begin
        gnt         = rst_i ? '0 : core_gnt;
        accept      = |gnt;
        ram_we_o    = accept &  req_write_i[gidx];
        ram_re_o    = accept & ~req_write_i[gidx];
        ram_addr_o  = accept ? req_addr_i[32'(gidx)*RAM_ADDR_BITS +: RAM_ADDR_BITS] : '0;
        ram_wdata_o = accept ? req_wdata_i[32'(gidx)*RAM_WIDTH +: RAM_WIDTH] : '0;
        rr_ptr_d    = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + IDX_W'(1);
        req_ready_o = gnt;
        rsp_valid_o = rsp_valid_q;
        rsp_data_o  = (|rsp_valid_q) ? ram_rdata_i : rsp_hold_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_hold_q  <= '0;
        end else begin
            rsp_valid_q <= gnt & ~req_write_i;
            if (|rsp_valid_q) rsp_hold_q <= ram_rdata_i;
            if (accept) begin
                rr_ptr_q <= rr_ptr_d;
                if (state_q == IDLE && req_lock_i[gidx]) begin
                    state_q <= LOCKED;
                    owner_q <= gidx;
                end else if (state_q == LOCKED && !req_lock_i[gidx]) begin
                    state_q <= IDLE;
                end
            end
        end
    end

`ifdef BRAM_ARB_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Saturating accepted-beat counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a read-first BRAM model attached.
module tb_bram_rr_arbiter;
    import bram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [51:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rsp_data, ram_wdata, ram_rdata;
    logic        ram_we, ram_re;
    logic [12:0] ram_addr;
    logic [15:0] grant_cnt;
    logic [7:0]  mem [0:8191];
    logic [3:0]  e;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_rr_arbiter #(.NUM_REQ(4), .RAM_WIDTH(8), .RAM_ADDR_BITS(13), .CNT_WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .ram_we_o    (ram_we),
        .ram_re_o    (ram_re),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .grant_cnt_o (grant_cnt)
    );

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_write = 4'b0000;
        req_lock  = 4'b0000;
        req_addr  = {13'h103, 13'h102, 13'h101, 13'h100};
        req_wdata = 32'h0;

        // Reset state, with requests pending during reset
        repeat (2) tick();
        #3;
        chk("rst_ready",  64'(req_ready), 64'h0);
        chk("rst_rspv",   64'(rsp_valid), 64'h0);
        chk("rst_we",     64'(ram_we),    64'h0);
        chk("rst_re",     64'(ram_re),    64'h0);
        chk("rst_addr",   64'(ram_addr),  64'h0);
        chk("rst_wdata",  64'(ram_wdata), 64'h0);
        chk("rst_cnt",    64'(grant_cnt), 64'h0);
        chk("rst_state",  64'(dut.state_q), 64'(IDLE));
        tick();
        rst       = 1'b0;
        req_valid = 4'b0000;

        // Four requesters reading: strict rotation, one response per cycle
        for (int k = 0; k < 8; k++) begin
            tick();
            req_valid = 4'b1111;
            #3;
            e = 4'b0001 << (k % 4);
            chk("t1_ready", 64'(req_ready), 64'(e));
            chk("t1_re",    64'(ram_re),    64'h1);
            chk("t1_addr",  64'(ram_addr),  64'(13'h100 + 13'(k % 4)));
            if (k > 0) begin
                e = 4'b0001 << ((k - 1) % 4);
                chk("t1_rspv", 64'(rsp_valid), 64'(e));
            end
        end
        tick();
        req_valid = 4'b0000;
        #3;
        chk("t1_last_rspv", 64'(rsp_valid), 64'h8);
        chk("t1_idle_ready", 64'(req_ready), 64'h0);
        chk("t1_idle_re",   64'(ram_re),    64'h0);
        chk("t1_idle_we",   64'(ram_we),    64'h0);

        // Write by req0 then read-back by req2
        tick();
        req_valid = 4'b0001;
        req_write = 4'b0001;
        req_addr[0 +: 13] = 13'h010;
        req_wdata = 32'h0000_00A5;
        #3;
        chk("t2_wr_ready", 64'(req_ready), 64'h1);
        chk("t2_wr_we",    64'(ram_we),    64'h1);
        chk("t2_wr_re",    64'(ram_re),    64'h0);
        chk("t2_wr_addr",  64'(ram_addr),  64'h010);
        chk("t2_wr_data",  64'(ram_wdata), 64'hA5);
        tick();
        req_valid = 4'b0100;
        req_write = 4'b0000;
        req_addr[26 +: 13] = 13'h010;
        #3;
        chk("t2_rd_ready", 64'(req_ready), 64'h4);
        chk("t2_rd_re",    64'(ram_re),    64'h1);
        chk("t2_rd_rspv0", 64'(rsp_valid), 64'h0);
        tick();
        req_valid = 4'b0000;
        #3;
        chk("t2_rspv", 64'(rsp_valid), 64'h4);
        chk("t2_rdata", 64'(rsp_data), 64'hA5);
        tick();
        #3;
        chk("t2_rspv_off", 64'(rsp_valid), 64'h0);
        chk("t2_hold",     64'(rsp_data),  64'hA5);

        // Lock by req1 for three beats with competitors waiting
        req_write = 4'b1111;
        tick();
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        #3;
        chk("t3_beat1", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1011;
        #3;
        chk("t3_beat2", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1001;
        req_lock  = 4'b0000;
        #3;
        chk("t3_owner_idle", 64'(req_ready), 64'h0);
        tick();
        req_valid = 4'b1011;
        #3;
        chk("t3_beat3", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b1001;
        #3;
        chk("t3_after_req3", 64'(req_ready), 64'h8);
        tick();
        #3;
        chk("t3_after_req0", 64'(req_ready), 64'h1);

        // Single continuous requester gets every cycle
        req_write = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            req_valid = 4'b1000;
            #3;
            chk("t4_ready", 64'(req_ready), 64'h8);
            if (k > 0) chk("t4_rspv", 64'(rsp_valid), 64'h8);
        end
        tick();
        req_valid = 4'b0000;

        // Reset while locked with a read in flight
        tick();
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        #3;
        chk("t5_lock_ready", 64'(req_ready), 64'h4);
        tick();
        #3;
        chk("t5_lock_ready2", 64'(req_ready), 64'h4);
        chk("t5_lock_rspv",   64'(rsp_valid), 64'h4);
        tick();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        #3;
        chk("t5_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        #3;
        chk("t5_rspv",  64'(rsp_valid), 64'h0);
        chk("t5_state", 64'(dut.state_q), 64'(IDLE));
        chk("t5_ready", 64'(req_ready), 64'h1);

        // Grant counters: 20 beats from req0 after a fresh reset
        tick();
        rst       = 1'b1;
        req_valid = 4'b0000;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_write = 4'b0001;
        repeat (10) tick();
        #3;
`ifdef BRAM_ARB_CNT_EN
        chk("t6_cnt10", 64'(grant_cnt), 64'h000A);
`else
        chk("t6_cnt10", 64'(grant_cnt), 64'h0000);
`endif
        repeat (10) tick();
        #3;
`ifdef BRAM_ARB_CNT_EN
        chk("t6_cnt20", 64'(grant_cnt), 64'h000F);
`else
        chk("t6_cnt20", 64'(grant_cnt), 64'h0000);
`endif
        req_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
